// File: rtl/dmrs_despreader.sv
// ============================================================================
//  Module      : dmrs_despreader
//  Description : Gold-sequence / orthogonal-cover despreader for DMRS samples
//                with 16-sample block correlation.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmrs_despreader #(
    parameter int SEQ_LEN = 20480,
    parameter int NC      = 1600,
    parameter int DW      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [30:0]          cinit,
    input  logic [15:0]          wn_pat,
    input  logic signed [DW-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic signed [DW:0]   dout,
    output logic                 dout_valid,
    output logic signed [DW+4:0] corr,
    output logic                 corr_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int NW = $clog2(SEQ_LEN);
    localparam int WW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state;
    logic [30:0]            x1;
    logic [30:0]            x2;
    logic [15:0]            wn;
    logic [NW-1:0]          n;
    logic [WW-1:0]          wcnt;
    logic signed [DW+4:0]   acc;

    logic                   x1_fb;
    logic                   x2_fb;
    logic                   flip;
    logic signed [DW:0]     din_ext;
    logic signed [DW:0]     desp;
    logic signed [DW+4:0]   desp_ext;
    logic signed [DW+4:0]   acc_sum;

    assign x1_fb    = x1[3] ^ x1[0];
    assign x2_fb    = x2[3] ^ x2[2] ^ x2[1] ^ x2[0];
    assign flip     = x1[0] ^ x2[0] ^ wn[n[3:0]];
    // One guard bit lets -2^(DW-1) negate to +2^(DW-1) cleanly.
    assign din_ext  = {din[DW-1], din};
    assign desp     = flip ? -din_ext : din_ext;
    assign desp_ext = {{4{desp[DW]}}, desp};
    assign acc_sum  = acc + desp_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            x1         <= '0;
            x2         <= '0;
            wn         <= '0;
            n          <= '0;
            wcnt       <= '0;
            acc        <= '0;
            din_ready  <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            corr       <= '0;
            corr_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            corr_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_WARMUP;
                        x1    <= 31'd1;
                        x2    <= cinit;
                        wn    <= wn_pat;
                        n     <= '0;
                        wcnt  <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                S_WARMUP: begin
                    x1   <= {x1_fb, x1[30:1]};
                    x2   <= {x2_fb, x2[30:1]};
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == WW'(NC - 1)) begin
                        state     <= S_RUN;
                        din_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (din_valid) begin
                        x1         <= {x1_fb, x1[30:1]};
                        x2         <= {x2_fb, x2[30:1]};
                        n          <= n + 1'b1;
                        dout       <= desp;
                        dout_valid <= 1'b1;
                        // Block boundary: publish the sum and restart with no gap.
                        if (n[3:0] == 4'hF) begin
                            corr       <= acc_sum;
                            corr_valid <= 1'b1;
                            acc        <= '0;
                        end else begin
                            acc <= acc_sum;
                        end
                        if (n == NW'(SEQ_LEN - 1)) begin
                            state     <= S_DONE;
                            din_ready <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmrs_despreader.sv
// ============================================================================
//  Module      : tb_dmrs_despreader
//  Description : Scoreboard bench for dmrs_despreader with a reference Gold model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmrs_despreader;

    localparam int SEQ_LEN = 32;
    localparam int NC      = 1600;
    localparam int DW      = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic [30:0]          cinit = '0;
    logic [15:0]          wn_pat = '0;
    logic signed [DW-1:0] din = '0;
    logic                 din_valid = 1'b0;
    logic                 din_ready;
    logic signed [DW:0]   dout;
    logic                 dout_valid;
    logic signed [DW+4:0] corr;
    logic                 corr_valid;
    logic                 busy;
    logic                 done;

    dmrs_despreader #(.SEQ_LEN(SEQ_LEN), .NC(NC), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .cinit(cinit), .wn_pat(wn_pat),
        .din(din), .din_valid(din_valid), .din_ready(din_ready), .dout(dout),
        .dout_valid(dout_valid), .corr(corr), .corr_valid(corr_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int  exp_dout[$];
    bit  exp_cv[$];
    int  exp_corr[$];
    bit  c_seq[SEQ_LEN];
    logic [15:0] wn_m;
    int  mn;
    int  acc_m;

    // Reference Gold sequence: c(n) for n = 0..SEQ_LEN-1 after NC warm-up shifts.
    task automatic build_gold(input logic [30:0] ci);
        logic [30:0] a;
        logic [30:0] b;
        logic fa, fb;
        a = 31'd1;
        b = ci;
        for (int i = 0; i < NC + SEQ_LEN; i++) begin
            if (i >= NC) c_seq[i - NC] = a[0] ^ b[0];
            fa = a[3] ^ a[0];
            fb = b[3] ^ b[2] ^ b[1] ^ b[0];
            a  = {fa, a[30:1]};
            b  = {fb, b[30:1]};
        end
    endtask

    function automatic bit model_flip();
        return c_seq[mn] ^ wn_m[mn % 16];
    endfunction

    function automatic int despread_model(input int d);
        return model_flip() ? -d : d;
    endfunction

    task automatic monitor();
        int e;
        int ce;
        bit cv;
        logic signed [DW:0]   ev;
        logic signed [DW+4:0] cev;
        forever begin
            @(negedge clk);
            if (dout_valid === 1'b1) begin
                checks++;
                if (exp_dout.size() == 0) begin
                    failures++;
                    $display("FAIL dout_unexpected: dout=%0d appeared with nothing expected", dout);
                end else begin
                    e  = exp_dout.pop_front();
                    cv = exp_cv.pop_front();
                    ev = e[DW:0];
                    if (dout !== ev) begin
                        failures++;
                        $display("FAIL dout: got %0d expected %0d", dout, ev);
                    end
                    checks++;
                    if (corr_valid !== cv) begin
                        failures++;
                        $display("FAIL corr_valid_align: got %b expected %b", corr_valid, cv);
                    end
                end
                if (corr_valid === 1'b1) begin
                    checks++;
                    if (exp_corr.size() == 0) begin
                        failures++;
                        $display("FAIL corr_unexpected: corr=%0d with nothing expected", corr);
                    end else begin
                        ce  = exp_corr.pop_front();
                        cev = ce[DW+4:0];
                        if (corr !== cev) begin
                            failures++;
                            $display("FAIL corr: got %0d expected %0d", corr, cev);
                        end
                    end
                end
            end else if (corr_valid === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL corr_valid_orphan: corr_valid=1 without dout_valid");
            end
        end
    endtask

    task automatic do_start(input logic [30:0] ci, input logic [15:0] wp, input bit inject);
        int cnt;
        build_gold(ci);
        wn_m  = wp;
        mn    = 0;
        acc_m = 0;
        @(posedge clk); #1;
        cinit  = ci;
        wn_pat = wp;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || din_ready !== 1'b0) begin
            failures++;
            $display("FAIL start_accept: busy=%b done=%b din_ready=%b expected 1/0/0", busy, done, din_ready);
        end
        cnt = 0;
        while (din_ready !== 1'b1 && cnt < NC + 50) begin
            if (inject && cnt == 100) begin
                start  = 1'b1;
                cinit  = ~ci;
                wn_pat = ~wp;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cnt++;
        end
        checks++;
        if (cnt != NC) begin
            failures++;
            $display("FAIL warmup_len: din_ready after %0d cycles expected %0d", cnt, NC);
        end
    endtask

    task automatic drive_sample(input int d, input int e, input bit gap, input bit pulse_start);
        din       = d[DW-1:0];
        din_valid = 1'b1;
        if (pulse_start) begin
            start  = 1'b1;
            cinit  = 31'h7FFF0000;
            wn_pat = 16'hFFFF;
        end
        exp_dout.push_back(e);
        acc_m += e;
        exp_cv.push_back(mn % 16 == 15);
        if (mn % 16 == 15) begin
            exp_corr.push_back(acc_m);
            acc_m = 0;
        end
        mn++;
        @(posedge clk); #1;
        din_valid = 1'b0;
        start     = 1'b0;
        din       = '0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic finish_run();
        checks++;
        if (done !== 1'b1 || din_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL run_end: done=%b din_ready=%b busy=%b expected 1/0/0", done, din_ready, busy);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (exp_dout.size() != 0 || exp_corr.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d dout and %0d corr still outstanding, expected 0/0",
                     exp_dout.size(), exp_corr.size());
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_hold: done=%b expected 1", done);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (din_ready !== 1'b0 || dout !== '0 || dout_valid !== 1'b0 || corr !== '0 ||
            corr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s: rdy=%b dout=%0d dv=%b corr=%0d cv=%b busy=%b done=%b expected all 0",
                     tag, din_ready, dout, dout_valid, corr, corr_valid, busy, done);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b1;
        din_valid = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check_all_zero("reset_state");
        reset     = 1'b0;
        start     = 1'b0;
        din_valid = 1'b0;
        @(posedge clk); #1;
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_gold_constant();
        do_start(31'd0, 16'h0000, 1'b0);
        for (int i = 0; i < SEQ_LEN; i++) drive_sample(5, despread_model(5), 1'b0, 1'b0);
        finish_run();
    endtask

    task automatic test_loopback();
        do_start(31'h12345678, 16'hA5C3, 1'b0);
        for (int i = 0; i < SEQ_LEN; i++) drive_sample(model_flip() ? -3 : 3, 3, 1'b0, 1'b0);
        finish_run();
    endtask

    task automatic test_overflow();
        logic [30:0] ci;
        logic [15:0] wp;
        ci = 31'h2B3C4D5E;
        build_gold(ci);
        for (int k = 0; k < 16; k++) wp[k] = ~c_seq[k];
        do_start(ci, wp, 1'b0);
        for (int i = 0; i < 16; i++) drive_sample(-128, 128, 1'b0, 1'b0);
        for (int i = 16; i < SEQ_LEN; i++) drive_sample(-128, despread_model(-128), 1'b0, 1'b0);
        finish_run();
    endtask

    task automatic test_gapped();
        int d;
        do_start(31'h0F0F1234, 16'h3C96, 1'b0);
        for (int i = 0; i < SEQ_LEN; i++) begin
            d = int'($urandom_range(0, 255)) - 128;
            drive_sample(d, despread_model(d), 1'b1, 1'b0);
        end
        finish_run();
    endtask

    task automatic test_reset_midrun();
        int dat[SEQ_LEN];
        for (int i = 0; i < SEQ_LEN; i++) dat[i] = int'($urandom_range(0, 255)) - 128;
        do_start(31'h55AA33CC, 16'h1234, 1'b0);
        for (int i = 0; i < 7; i++) drive_sample(dat[i], despread_model(dat[i]), 1'b0, 1'b0);
        din       = dat[7][DW-1:0];
        din_valid = 1'b1;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        din_valid = 1'b0;
        check_all_zero("midrun_reset");
        checks++;
        if (exp_dout.size() != 0 || exp_corr.size() != 0) begin
            failures++;
            $display("FAIL midrun_drain: %0d dout %0d corr outstanding expected 0/0",
                     exp_dout.size(), exp_corr.size());
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_all_zero("midrun_idle");
        do_start(31'h55AA33CC, 16'h1234, 1'b0);
        for (int i = 0; i < SEQ_LEN; i++) drive_sample(dat[i], despread_model(dat[i]), 1'b0, 1'b0);
        finish_run();
    endtask

    task automatic test_ignore_start();
        int d;
        do_start(31'h3EADBEEF, 16'hF00D, 1'b1);
        for (int i = 0; i < SEQ_LEN - 1; i++) begin
            d = int'($urandom_range(0, 255)) - 128;
            drive_sample(d, despread_model(d), 1'b0, i == 10);
        end
        checks++;
        if (done !== 1'b0 || din_ready !== 1'b1) begin
            failures++;
            $display("FAIL pre_last: done=%b din_ready=%b expected 0/1", done, din_ready);
        end
        drive_sample(77, despread_model(77), 1'b0, 1'b0);
        finish_run();
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_gold_constant();
        test_loopback();
        test_overflow();
        test_gapped();
        test_reset_midrun();
        test_ignore_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
